multi_dig_svn_seg_scanner: RTL and testbench
============================================

// Module: multi_dig_svn_seg_scanner
// PURPOSE
//  Parametrised, time-multiplexed hex display driver for N_DIG seven-segment digits.
//  Selects between two nibble-packed sources and captures the selection into a
//  shadow register only at a frame boundary, so the display never tears mid-scan.
//  Adds leading-zero blanking and per-digit blinking.
//  Sits between datapath blocks (e.g. the FP adder controller) and the board pins.
// PARAMETERS
//  N_DIG         4      number of digits scanned; valid range 2..8
//  SCAN_DIV      100000 clk cycles per digit slot (>=2)
//  BLINK_FRAMES  64     frames per blink half-period (>=1)
// PORTS
//  clk         in   1        system clock, all logic rising-edge
//  clr         in   1        synchronous reset, active-high
//  src0        in   4*N_DIG  source 0; digit 0 (rightmost) = src0[3:0]
//  src1        in   4*N_DIG  source 1, same packing
//  sel         in   1        0 = src0, 1 = src1; sampled only at capture
//  load        in   1        request capture of selected source at next frame boundary
//  blank_lz    in   1        1 = blank leading zero digits
//  blink_mask  in   N_DIG    bit k = 1 -> digit k blinks
//  an          out  N_DIG    anode enables, active-low, an[k] = digit k
//  ca          out  7        cathodes, active-low, ca[0]=seg a .. ca[6]=seg g
//  frame       out  1        one-cycle pulse on each frame boundary
// BEHAVIOUR
//  Reset (clr=1 at clk edge, dominates all): an=all 1s, ca=7'h7F, frame=0,
//   prescaler=0, digit index=0, shadow reg=0, load_pending=0, blink phase=on, blink cnt=0.
//  Prescaler counts 0..SCAN_DIV-1, wraps; tick = (count==SCAN_DIV-1).
//  On tick: index <= (index==N_DIG-1) ? 0 : index+1.
//  Frame boundary = tick with index==N_DIG-1; frame registered, high the cycle after.
//  Capture: load sets load_pending. At boundary, if load_pending|load:
//   shadow <= sel ? src1 : src0 (sampled that cycle); load_pending <= 0.
//   load asserted while already pending: no extra effect. sel/src changes without
//   a capture never alter the display.
//  Blink: blink cnt increments per boundary; at BLINK_FRAMES-1 wraps to 0 and toggles phase.
//  Digit k blanked when: (blink_mask[k] & phase==off) OR leading-zero condition.
//  Leading zero: blank_lz=1, k>=1, and nibbles k..N_DIG-1 of shadow all zero.
//   Digit 0 never LZ-blanked (value 0 shows "0").
//  Output regs: one cycle after index becomes k: an = ~(1<<k); ca = blanked ? 7'h7F
//   : ~hex_seg(nibble k). Exactly one an bit low at any time after first post-reset cycle.
//  hex_seg (gfedcba, active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//   8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//  Reset mid-frame: scan restarts at digit 0; pending load discarded; shadow cleared.
// TESTING (N_DIG=4, SCAN_DIV=4, BLINK_FRAMES=2)
//  1 clr 2 cycles, release -> an=4'hF,ca=7F during reset; then an walks E,D,B,7,E
//    every 4 cycles; frame pulses every 16 cycles; shadow=0 so digit0 ca=7'h40.
//  2 src0=16'h12AF, sel=0, load 1 cycle mid-frame -> no change until boundary;
//    next frame shows F,A,2,1 (ca 0E,08,24,79) on digits 0..3.
//  3 load pending, then sel 0->1 (src1=16'h00C3) before boundary -> shadow=00C3;
//    blank_lz=1 -> digits 2,3 ca=7F; digit1 ca=46, digit0 ca=30.
//  4 shadow=0, blank_lz=1 -> digits 3..1 blank, digit0 shows 0 (ca=40).
//  5 blink_mask=4'b0001 -> digit0 ca alternates valid/7F every 2 frames; others steady.
//  6 clr asserted during digit 2 slot with load pending -> reset values next cycle;
//    after release display 0000 and no capture at next boundary.

Source files
------------

// File: rtl/multi_dig_svn_seg_scanner.sv
// Time-multiplexed N_DIG-digit hex display driver with frame-synchronous source
// capture, leading-zero blanking and per-digit blinking.
module multi_dig_svn_seg_scanner #(
  parameter int N_DIG        = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [4*N_DIG-1:0] src0,
  input  logic [4*N_DIG-1:0] src1,
  input  logic               sel,
  input  logic               load,
  input  logic               blank_lz,
  input  logic [N_DIG-1:0]   blink_mask,
  output logic [N_DIG-1:0]   an,
  output logic [6:0]         ca,
  output logic               frame
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIG);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {PH_ON, PH_OFF} phase_t;

  logic [PW-1:0]      presc;
  logic [IW-1:0]      idx;
  logic [4*N_DIG-1:0] shadow;
  logic               load_pending;
  logic [BW-1:0]      bcnt;
  phase_t             phase;
  phase_t             phase_next;
  logic               tick;
  logic               boundary;
  logic               last_blink;
  logic               upper_zero;
  logic [N_DIG-1:0]   lz;
  logic [3:0]         nib;
  logic               blank;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      default: hex_seg = 7'h71;
    endcase
  endfunction

  assign tick       = (presc == PW'(SCAN_DIV - 1));
  assign boundary   = tick && (idx == IW'(N_DIG - 1));
  assign last_blink = (bcnt == BW'(BLINK_FRAMES - 1));

  // Scan from the top digit down; a digit is a leading zero while all digits above it are zero.
  always_comb begin
    upper_zero = 1'b1;
    lz         = '0;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      upper_zero = upper_zero & (shadow[4*(N_DIG-1-i) +: 4] == 4'h0);
      lz[N_DIG-1-i] = blank_lz & upper_zero & (i < N_DIG - 1);
    end
  end

  always_comb begin
    nib   = 4'h0;
    blank = 1'b0;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (idx == IW'(i)) begin
        nib   = shadow[4*i +: 4];
        blank = lz[i] | (blink_mask[i] & (phase == PH_OFF));
      end
    end
  end

  always_comb begin
    phase_next = phase;
    if (boundary && last_blink)
      phase_next = (phase == PH_ON) ? PH_OFF : PH_ON;
  end

  always_ff @(posedge clk) begin
    if (clr) phase <= PH_ON;
    else     phase <= phase_next;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      presc        <= '0;
      idx          <= '0;
      shadow       <= '0;
      load_pending <= 1'b0;
      bcnt         <= '0;
      an           <= '1;
      ca           <= '1;
      frame        <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)
        idx <= (idx == IW'(N_DIG - 1)) ? '0 : idx + 1'b1;
      frame <= boundary;
      if (boundary) begin
        if (load_pending | load)
          shadow <= sel ? src1 : src0;
        load_pending <= 1'b0;
        bcnt         <= last_blink ? '0 : bcnt + 1'b1;
      end else if (load) begin
        load_pending <= 1'b1;
      end
      an <= ~(N_DIG'(1) << idx);
      ca <= blank ? 7'h7F : ~hex_seg(nib);
    end
  end

endmodule

// File: tb/tb_multi_dig_svn_seg_scanner.sv
// Self-checking bench: per-cycle reference model, vector table and corner sequences.
module tb_multi_dig_svn_seg_scanner;

  localparam int N  = 4;
  localparam int S  = 4;
  localparam int BF = 2;
  localparam int FRAME_CYC = S * N;

  logic          clk = 1'b0;
  logic          clr, sel, load, blank_lz;
  logic [15:0]   src0, src1;
  logic [3:0]    blink_mask;
  logic [3:0]    an;
  logic [6:0]    ca;
  logic          frame;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int          mc;
  int          mframes;
  logic [15:0] mshadow;
  logic        mpend;
  logic [3:0]  e_an;
  logic [6:0]  e_ca;
  logic        e_frame;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [15:0]     s0;
    logic [15:0]     s1;
    logic            sl;
    logic            blz;
    logic [3:0][6:0] exp; // digit3 .. digit0
  } vec_t;

  vec_t       vecs [9];
  logic [6:0] seen [4];

  multi_dig_svn_seg_scanner #(.N_DIG(N), .SCAN_DIV(S), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .clr(clr), .src0(src0), .src1(src1), .sel(sel), .load(load),
    .blank_lz(blank_lz), .blink_mask(blink_mask), .an(an), .ca(ca), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_ca(input logic [15:0] sh, input int k,
                                          input logic blz, input logic [3:0] mask,
                                          input logic ph_off);
    logic [15:0] upper;
    logic        lzb;
    upper = sh >> (4 * k);
    lzb   = blz && (k >= 1) && (upper == 16'h0);
    if ((mask[k] && ph_off) || lzb) return 7'h7F;
    return ~seg_tab[sh[4*k +: 4]];
  endfunction

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic step();
    int  idx;
    bit  bnd;
    @(posedge clk);
    if (clr) begin
      mc = 0; mframes = 0; mshadow = '0; mpend = 1'b0;
      e_an = 4'hF; e_ca = 7'h7F; e_frame = 1'b0;
    end else begin
      idx     = (mc / S) % N;
      bnd     = (mc % FRAME_CYC) == FRAME_CYC - 1;
      e_an    = ~(4'b0001 << idx);
      e_ca    = model_ca(mshadow, idx, blank_lz, blink_mask, ((mframes / BF) % 2) == 1);
      e_frame = bnd;
      if (bnd) begin
        if (mpend || load) mshadow = sel ? src1 : src0;
        mpend = 1'b0;
        mframes++;
      end else if (load) begin
        mpend = 1'b1;
      end
      mc++;
    end
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("ca", 32'(ca), 32'(e_ca));
    chk("frame", 32'(frame), 32'(e_frame));
  endtask

  task automatic wait_frame(input string name);
    int k;
    for (k = 0; k < 2 * FRAME_CYC; k++) begin
      step();
      if (frame === 1'b1) break;
    end
    if (k == 2 * FRAME_CYC) begin
      n_chk++; n_fail++;
      $display("FAIL %s: frame pulse timeout actual=none required=pulse", name);
    end
  endtask

  task automatic wait_digit(input int d, input string name);
    int k;
    for (k = 0; k < 2 * FRAME_CYC; k++) begin
      step();
      if (an === ~(4'b0001 << d)) break;
    end
    if (k == 2 * FRAME_CYC) begin
      n_chk++; n_fail++;
      $display("FAIL %s: digit %0d never selected", name, d);
    end
  endtask

  // Called right after a frame pulse: the next 16 cycles show digits 0..3.
  task automatic record_frame();
    for (int k = 0; k < 4; k++) seen[k] = 7'hxx;
    for (int c = 0; c < FRAME_CYC; c++) begin
      step();
      for (int k = 0; k < 4; k++)
        if (an === ~(4'b0001 << k)) seen[k] = ca;
    end
  endtask

  task automatic pulse_load();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int pulses;
    int off_frames;

    vecs[0] = '{16'h12AF, 16'h0000, 1'b0, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}};
    vecs[1] = '{16'h0000, 16'h00C3, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h46, 7'h30}};
    vecs[2] = '{16'h0000, 16'h0000, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[4] = '{16'h0000, 16'h8000, 1'b1, 1'b1, {7'h00, 7'h40, 7'h40, 7'h40}};
    vecs[5] = '{16'h0050, 16'h0000, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}};
    vecs[6] = '{16'h0400, 16'h0000, 1'b0, 1'b1, {7'h7F, 7'h19, 7'h40, 7'h40}};
    vecs[7] = '{16'hBDE6, 16'h0000, 1'b0, 1'b0, {7'h03, 7'h21, 7'h06, 7'h02}};
    vecs[8] = '{16'h7908, 16'h0000, 1'b0, 1'b1, {7'h78, 7'h10, 7'h40, 7'h00}};

    mc = 0; mframes = 0; mshadow = '0; mpend = 1'b0;
    clr = 1'b1; sel = 1'b0; load = 1'b0; blank_lz = 1'b0;
    src0 = '0; src1 = '0; blink_mask = '0;

    // reset and scan walk
    step(); step();
    chk("reset_an", 32'(an), 32'h0000000F);
    chk("reset_ca", 32'(ca), 32'h0000007F);
    clr = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4 * FRAME_CYC; c++) begin
      step();
      if (frame === 1'b1) pulses++;
    end
    chk("frame_pulse_count", 32'(pulses), 32'd4);

    // table of captured values; the unselected source carries garbage
    foreach (vecs[i]) begin
      wait_digit(1, "vec_sync");
      src0 = vecs[i].sl ? 16'($urandom) : vecs[i].s0;
      src1 = vecs[i].sl ? vecs[i].s1 : 16'($urandom);
      sel = vecs[i].sl; blank_lz = vecs[i].blz;
      pulse_load();
      wait_frame("vec_capture");
      record_frame();
      for (int k = 0; k < 4; k++)
        chk($sformatf("vec%0d_digit%0d", i, k), 32'(seen[k]), 32'(vecs[i].exp[k]));
    end

    // pending load, then sel flips before the boundary
    blank_lz = 1'b1;
    wait_digit(1, "sel_sync");
    src0 = 16'hFFFF; sel = 1'b0; src1 = 16'h00C3;
    pulse_load();
    step();
    sel = 1'b1;
    src0 = 16'h1111;
    wait_frame("sel_capture");
    record_frame();
    chk("selflip_d0", 32'(seen[0]), 32'h30);
    chk("selflip_d1", 32'(seen[1]), 32'h46);
    chk("selflip_d3", 32'(seen[3]), 32'h7F);

    // blinking digit 0 over 8 frames
    blank_lz = 1'b0; src0 = 16'h0001; sel = 1'b0;
    pulse_load();
    wait_frame("blink_capture");
    blink_mask = 4'b0001;
    off_frames = 0;
    for (int f = 0; f < 8; f++) begin
      record_frame();
      if (seen[0] === 7'h7F) off_frames++;
      chk("blink_d1_steady", 32'(seen[1]), 32'h40);
    end
    chk("blink_off_frames", 32'(off_frames), 32'd4);
    blink_mask = '0;

    // reset during digit 2 slot with load pending
    src0 = 16'hFFFF;
    wait_digit(1, "clr_sync");
    pulse_load();
    wait_digit(2, "clr_digit2");
    clr = 1'b1;
    step();
    chk("midclr_an", 32'(an), 32'h0000000F);
    chk("midclr_ca", 32'(ca), 32'h0000007F);
    chk("midclr_frame", 32'(frame), 32'h0);
    clr = 1'b0;
    wait_frame("midclr_frame_wait");
    record_frame();
    for (int k = 0; k < 4; k++)
      chk($sformatf("midclr_digit%0d", k), 32'(seen[k]), 32'h40);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      load = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0)   sel = 1'($urandom);
      if ($urandom_range(0, 49) == 0)  src0 = ($urandom_range(0, 1) == 0) ? 16'($urandom & 32'h00FF) : 16'($urandom);
      if ($urandom_range(0, 49) == 0)  src1 = 16'($urandom);
      if ($urandom_range(0, 99) == 0)  blank_lz = ~blank_lz;
      if ($urandom_range(0, 99) == 0)  blink_mask = 4'($urandom);
      clr = ($urandom_range(0, 499) == 0);
      step();
    end
    clr = 1'b0; load = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
